// File: rtl/det_pkg.sv
// rtl/det_pkg.sv - shared types, default sizes and width helper for the detection event logger
package det_pkg;

   localparam int TS_W_DEF  = 16;
   localparam int DEPTH_DEF = 8;
   localparam int HIT_W_DEF = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Ceiling log2, used for pointer and occupancy widths
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/det_event_logger_if.sv
// rtl/det_event_logger_if.sv - valid/ready read port carrying queued timestamps
interface det_event_logger_if
   import det_pkg::*;
#(
   parameter int TS_W = TS_W_DEF
);
   logic            rd_valid;
   logic            rd_ready;
   logic [TS_W-1:0] rd_data;

   modport master (output rd_valid, output rd_data, input rd_ready);
   modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

// File: rtl/det_ts_fifo.sv
// rtl/det_ts_fifo.sv - DEPTH x DW timestamp FIFO with registered head; DET_LOGGER_OVERWRITE_EN selects overwrite-oldest when full
module det_ts_fifo
   import det_pkg::*;
#(
   parameter int DW    = TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  push,
   input  logic [DW-1:0]         wdata,
   input  logic                  pop,
   output logic [DW-1:0]         head,
   output logic                  full,
   output logic                  empty,
   output logic [clog2(DEPTH):0] level
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]   wr_q, wr_d;
   logic [AW:0]   rd_q, rd_d;
   logic [DW-1:0] head_q, head_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic          do_push;
   logic          do_pop;
   logic          adv_rd;

   // Extra-MSB pointers: equal means empty, differing only in MSB means full
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign level = wr_q - rd_q;
   assign head  = head_q;

   // Qualify push/pop; clr discards both
   always_comb begin
      do_pop = pop && !empty && !clr;
`ifdef DET_LOGGER_OVERWRITE_EN
      // When full, the push evicts the oldest entry; a coincident pop already made room
      do_push = push && !clr;
      adv_rd  = do_pop || (do_push && full);
`else
      // When full, the new entry is dropped even if a pop happens in the same cycle
      do_push = push && !full && !clr;
      adv_rd  = do_pop;
`endif
   end

   // Next pointers and next head; head forwards write data when the new head is the slot being written
   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      head_d = head_q;
      if (clr) begin
         wr_d   = '0;
         rd_d   = '0;
         head_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + PTR_ONE;
         if (adv_rd)  rd_d = rd_q + PTR_ONE;
         if (wr_d != rd_d) begin
            if (do_push && (rd_d[AW-1:0] == wr_q[AW-1:0])) head_d = wdata;
            else                                           head_d = mem_q[rd_d[AW-1:0]];
         end
      end
   end

   // Pointer and head registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         head_q <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         head_q <= head_d;
      end
   end

   // Storage array, no reset needed since reads are gated by the pointers
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/det_event_logger.sv
// rtl/det_event_logger.sv - timestamps detector pulses into a FIFO with hit count and sticky overflow; DET_LOGGER_OVERWRITE_EN enables overwrite-oldest
module det_event_logger
   import det_pkg::*;
#(
   parameter int TS_W  = TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int HIT_W = HIT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    det,
   input  logic                    en,
   input  logic                    clr,
   det_event_logger_if.master      rd,
   output logic [clog2(DEPTH):0]   level,
   output logic [HIT_W-1:0]        hits,
   output logic                    overflow
);

   localparam logic [TS_W-1:0]  TS_ONE  = 1;
   localparam logic [HIT_W-1:0] HIT_ONE = 1;

   state_e          state_q, state_d;
   logic [TS_W-1:0] ts_q, ts_d;
   logic [HIT_W-1:0] hits_q, hits_d;
   logic            overflow_q, overflow_d;
   logic            accept;
   logic            fifo_full;
   logic            fifo_empty;

   assign accept   = det && (state_q == RUN) && !clr;
   assign hits     = hits_q;
   assign overflow = overflow_q;
   assign rd.rd_valid = !fifo_empty;

   // Enable FSM, free-running timestamp, saturating hit count and sticky overflow
   always_comb begin
      state_d    = state_q;
      ts_d       = ts_q;
      hits_d     = hits_q;
      overflow_d = overflow_q;
      if (clr) begin
         state_d    = IDLE;
         ts_d       = '0;
         hits_d     = '0;
         overflow_d = 1'b0;
      end else begin
         case (state_q)
            IDLE:    if (en)  state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
         endcase
         if (state_q == RUN) ts_d = ts_q + TS_ONE;
         if (accept && (hits_q != '1)) hits_d = hits_q + HIT_ONE;
         if (accept && fifo_full) overflow_d = 1'b1;
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         ts_q       <= '0;
         hits_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ts_q       <= ts_d;
         hits_q     <= hits_d;
         overflow_q <= overflow_d;
      end
   end

   det_ts_fifo #(
      .DW    (TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .push  (accept),
      .wdata (ts_q),
      .pop   (rd.rd_ready),
      .head  (rd.rd_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

endmodule

// File: tb/tb_det_event_logger.sv
// tb/tb_det_event_logger.sv - directed self-checking bench for det_event_logger
module tb_det_event_logger;
   import det_pkg::*;

`ifdef DET_LOGGER_OVERWRITE_EN
   localparam bit OVW = 1'b1;
`else
   localparam bit OVW = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        det = 1'b0;
   logic        en  = 1'b0;
   logic        clr = 1'b0;
   logic [3:0]  level;
   logic [15:0] hits;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   det_event_logger_if #(.TS_W(16)) rd_if ();

   det_event_logger #(
      .TS_W  (16),
      .DEPTH (8),
      .HIT_W (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .det      (det),
      .en       (en),
      .clr      (clr),
      .rd       (rd_if),
      .level    (level),
      .hits     (hits),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled on the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_n(input int n);
      det = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse();
      det = 1'b1;
      step();
      det = 1'b0;
   endtask

   task automatic do_clear();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   initial begin
      rd_if.rd_ready = 1'b0;

      // Reset values
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_valid", 32'(rd_if.rd_valid), 32'd0);
      check_eq("rst_data", 32'(rd_if.rd_data), 32'd0);
      check_eq("rst_level", 32'(level), 32'd0);
      check_eq("rst_hits", 32'(hits), 32'd0);
      check_eq("rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b1;
      step();

      // Stamps 3, 7, 12 with rd_ready held high
      en = 1'b1;
      rd_if.rd_ready = 1'b1;
      step();
      wait_n(3);
      pulse();
      check_eq("t1_valid_a", 32'(rd_if.rd_valid), 32'd1);
      check_eq("t1_data_a", 32'(rd_if.rd_data), 32'd3);
      wait_n(3);
      check_eq("t1_level_popped", 32'(level), 32'd0);
      pulse();
      check_eq("t1_data_b", 32'(rd_if.rd_data), 32'd7);
      wait_n(4);
      pulse();
      check_eq("t1_data_c", 32'(rd_if.rd_data), 32'd12);
      wait_n(2);
      check_eq("t1_level_end", 32'(level), 32'd0);
      check_eq("t1_valid_end", 32'(rd_if.rd_valid), 32'd0);
      check_eq("t1_hits", 32'(hits), 32'd3);
      check_eq("t1_ovf", 32'(overflow), 32'd0);
      check_eq("t1_data_hold", 32'(rd_if.rd_data), 32'd12);

      // Nine pulses into an eight-deep FIFO, then drain
      rd_if.rd_ready = 1'b0;
      do_clear();
      step();
      for (int i = 0; i < 8; i++) pulse();
      check_eq("t2_level_8", 32'(level), 32'd8);
      check_eq("t2_ovf_before", 32'(overflow), 32'd0);
      pulse();
      check_eq("t2_level_full", 32'(level), 32'd8);
      check_eq("t2_ovf", 32'(overflow), 32'd1);
      check_eq("t2_hits", 32'(hits), 32'd9);
      rd_if.rd_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check_eq("t2_drain_valid", 32'(rd_if.rd_valid), 32'd1);
         check_eq("t2_drain_data", 32'(rd_if.rd_data), OVW ? 32'(i + 1) : 32'(i));
         step();
      end
      check_eq("t2_level_empty", 32'(level), 32'd0);
      check_eq("t2_valid_empty", 32'(rd_if.rd_valid), 32'd0);

      // Full FIFO with a pop and an event in the same cycle
      rd_if.rd_ready = 1'b0;
      do_clear();
      step();
      for (int i = 0; i < 8; i++) pulse();
      check_eq("t3_level_full", 32'(level), 32'd8);
      det = 1'b1;
      rd_if.rd_ready = 1'b1;
      step();
      det = 1'b0;
      rd_if.rd_ready = 1'b0;
      check_eq("t3_level", 32'(level), OVW ? 32'd8 : 32'd7);
      check_eq("t3_ovf", 32'(overflow), 32'd1);
      check_eq("t3_hits", 32'(hits), 32'd9);
      check_eq("t3_head", 32'(rd_if.rd_data), 32'd1);
      rd_if.rd_ready = 1'b1;
      step();
      step();
      step();
      rd_if.rd_ready = 1'b0;
      check_eq("t3_level_after_pops", 32'(level), OVW ? 32'd5 : 32'd4);
      check_eq("t3_head_after_pops", 32'(rd_if.rd_data), 32'd4);

      // clr together with an event and a pop
      clr = 1'b1;
      det = 1'b1;
      rd_if.rd_ready = 1'b1;
      step();
      clr = 1'b0;
      det = 1'b0;
      rd_if.rd_ready = 1'b0;
      check_eq("t5_level", 32'(level), 32'd0);
      check_eq("t5_hits", 32'(hits), 32'd0);
      check_eq("t5_ovf", 32'(overflow), 32'd0);
      check_eq("t5_valid", 32'(rd_if.rd_valid), 32'd0);
      check_eq("t5_data", 32'(rd_if.rd_data), 32'd0);
      step();
      wait_n(5);
      pulse();
      check_eq("t5_ts_restart", 32'(rd_if.rd_data), 32'd5);

      // en low for five cycles freezes the timestamp at 20
      do_clear();
      step();
      wait_n(19);
      en = 1'b0;
      step();
      step();
      pulse();
      step();
      step();
      check_eq("t4_hits_frozen", 32'(hits), 32'd0);
      check_eq("t4_level_frozen", 32'(level), 32'd0);
      en = 1'b1;
      step();
      wait_n(2);
      pulse();
      check_eq("t4_stamp", 32'(rd_if.rd_data), 32'd22);
      check_eq("t4_hits", 32'(hits), 32'd1);
      check_eq("t4_level", 32'(level), 32'd1);

      // Saturating hit counter
      do_clear();
      step();
      rd_if.rd_ready = 1'b1;
      det = 1'b1;
      for (int i = 0; i < 65534; i++) step();
      check_eq("t6_hits_fffe", 32'(hits), 32'hFFFE);
      step();
      check_eq("t6_hits_ffff", 32'(hits), 32'hFFFF);
      step();
      step();
      det = 1'b0;
      check_eq("t6_hits_sat", 32'(hits), 32'hFFFF);
      check_eq("t6_ovf", 32'(overflow), 32'd0);

      // Asynchronous reset in the middle of a drain
      rd_if.rd_ready = 1'b0;
      do_clear();
      step();
      pulse();
      pulse();
      pulse();
      check_eq("t7_level", 32'(level), 32'd3);
      rd_if.rd_ready = 1'b1;
      step();
      check_eq("t7_head", 32'(rd_if.rd_data), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check_eq("t7_valid", 32'(rd_if.rd_valid), 32'd0);
      check_eq("t7_data", 32'(rd_if.rd_data), 32'd0);
      check_eq("t7_level_rst", 32'(level), 32'd0);
      check_eq("t7_hits_rst", 32'(hits), 32'd0);
      check_eq("t7_ovf_rst", 32'(overflow), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
